// File: rtl/dvi_tx_pkg.sv
// Shared definitions for the TMDS/HDMI lane encoder: period modes,
// control tokens, the TERC4 table and the 8b/10b transition-minimising helpers.
package dvi_tx_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'd0,
    MODE_VIDEO = 2'd1,
    MODE_TERC4 = 2'd2,
    MODE_GUARD = 2'd3
  } mode_e;

  localparam logic [9:0] CTRL_00       = 10'b1101010100;
  localparam logic [9:0] CTRL_01       = 10'b0010101011;
  localparam logic [9:0] CTRL_10       = 10'b0101010100;
  localparam logic [9:0] CTRL_11       = 10'b1010101011;
  localparam logic [9:0] GUARD_DEFAULT = 10'b1011001100;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  function automatic logic [9:0] terc4_symbol(input logic [3:0] nib);
    case (nib)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  // Number of ones in a byte (0..8).
  function automatic logic [3:0] n1_count(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, d[i]};
    return n;
  endfunction

  function automatic logic [8:0] encode_xor(input logic [7:0] d);
    logic [8:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
    q[8] = 1'b1;
    return q;
  endfunction

  function automatic logic [8:0] encode_xnor(input logic [7:0] d);
    logic [8:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
    q[8] = 1'b0;
    return q;
  endfunction

endpackage

// File: rtl/dvi_tx_tmds_lane.sv
// One TMDS lane: five-stage pipeline (ones count, q_m, balance, DC-balance
// with running disparity, period mux). Mode travels with the data so that
// every symbol leaves with the period it entered with.
module dvi_tx_tmds_lane
  import dvi_tx_pkg::*;
#(
  parameter bit         TERC4_EN  = 1'b1,
  parameter logic [9:0] GUARD_SYM = GUARD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cke,
  input  logic [1:0] in_mode,
  input  logic [7:0] in_d,
  input  logic [1:0] in_c,
  input  logic [3:0] in_terc4,
  output logic [9:0] out_d
);

  mode_e             w_mode;
  mode_e             r_s1_mode, r_s2_mode, r_s3_mode, r_s4_mode;
  logic [1:0]        r_s1_c, r_s2_c, r_s3_c, r_s4_c;
  logic [3:0]        r_s1_t, r_s2_t, r_s3_t, r_s4_t;
  logic [7:0]        r_s1_d;
  logic [3:0]        r_s1_n1;
  logic [8:0]        r_s2_qm, r_s3_qm, w_qm;
  logic              w_use_xnor;
  logic [3:0]        w_n1_qm;
  logic signed [4:0] w_n, r_s3_n;
  logic signed [4:0] r_cnt, w_cnt_next;
  logic [9:0]        w_sym, r_s4_sym, w_out_next, r_out;

  // Input mode qualification: TERC4 folds onto CTRL when the mode is disabled.
  // NOTE: combinational blocks assign every output a default first, so no path leaves a latch.
  always_comb begin
    w_mode = mode_e'(in_mode);
    if (!TERC4_EN && (w_mode == MODE_TERC4)) w_mode = MODE_CTRL;
  end

  // S2 logic: pick XOR or XNOR chain to minimise transitions.
  always_comb begin
    w_use_xnor = (r_s1_n1 > 4'd4) || ((r_s1_n1 == 4'd4) && !r_s1_d[0]);
    w_qm       = w_use_xnor ? encode_xnor(r_s1_d) : encode_xor(r_s1_d);
  end

  // S3 logic: ones minus zeros of q_m[7:0], i.e. 2*N1 - 8.
  always_comb begin
    w_n1_qm = n1_count(r_s2_qm[7:0]);
    w_n     = $signed({w_n1_qm, 1'b0} - 5'd8);
  end

  // S4 logic: DC-balancing decision and running disparity update.
  always_comb begin
    w_sym      = {1'b0, r_s3_qm[8], r_s3_qm[7:0]};
    w_cnt_next = r_cnt;
    if ((r_cnt == 5'sd0) || (r_s3_n == 5'sd0)) begin
      w_sym      = {~r_s3_qm[8], r_s3_qm[8], r_s3_qm[8] ? r_s3_qm[7:0] : ~r_s3_qm[7:0]};
      w_cnt_next = r_s3_qm[8] ? (r_cnt + r_s3_n) : (r_cnt - r_s3_n);
    end else if (r_cnt[4] == r_s3_n[4]) begin
      w_sym      = {1'b1, r_s3_qm[8], ~r_s3_qm[7:0]};
      w_cnt_next = r_cnt + (r_s3_qm[8] ? 5'sd2 : 5'sd0) - r_s3_n;
    end else begin
      w_sym      = {1'b0, r_s3_qm[8], r_s3_qm[7:0]};
      w_cnt_next = r_cnt - (r_s3_qm[8] ? 5'sd0 : 5'sd2) + r_s3_n;
    end
    if (r_s3_mode != MODE_VIDEO) w_cnt_next = 5'sd0;
  end

  // S5 logic: select the symbol for the period type carried in S4.
  always_comb begin
    w_out_next = ctrl_token(r_s4_c);
    case (r_s4_mode)
      MODE_VIDEO: w_out_next = r_s4_sym;
      MODE_TERC4: w_out_next = terc4_symbol(r_s4_t);
      MODE_GUARD: w_out_next = GUARD_SYM;
      default:    w_out_next = ctrl_token(r_s4_c);
    endcase
  end

  // Control path registers: modes, control codes, disparity and output symbol.
  // NOTE: sequential state uses non-blocking assignments so every stage sees the previous stage's old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_mode <= MODE_CTRL;
      r_s2_mode <= MODE_CTRL;
      r_s3_mode <= MODE_CTRL;
      r_s4_mode <= MODE_CTRL;
      r_s1_c    <= 2'b00;
      r_s2_c    <= 2'b00;
      r_s3_c    <= 2'b00;
      r_s4_c    <= 2'b00;
      r_cnt     <= 5'sd0;
      r_out     <= CTRL_00;
    end else if (cke) begin
      r_s1_mode <= w_mode;
      r_s2_mode <= r_s1_mode;
      r_s3_mode <= r_s2_mode;
      r_s4_mode <= r_s3_mode;
      r_s1_c    <= in_c;
      r_s2_c    <= r_s1_c;
      r_s3_c    <= r_s2_c;
      r_s4_c    <= r_s3_c;
      r_cnt     <= w_cnt_next;
      r_out     <= w_out_next;
    end
  end

  // Data path registers: payload of each stage, qualified by the staged mode.
  // NOTE: these are left unreset; the reset modes are CTRL so their contents never reach out_d.
  always_ff @(posedge clk) begin
    if (cke) begin
      r_s1_d   <= in_d;
      r_s1_n1  <= n1_count(in_d);
      r_s1_t   <= in_terc4;
      r_s2_qm  <= w_qm;
      r_s2_t   <= r_s1_t;
      r_s3_qm  <= r_s2_qm;
      r_s3_n   <= w_n;
      r_s3_t   <= r_s2_t;
      r_s4_sym <= w_sym;
      r_s4_t   <= r_s3_t;
    end
  end

  assign out_d = r_out;

endmodule

// File: rtl/dvi_tx_tmds_encoder.sv
// N-lane TMDS/HDMI symbol encoder. Lanes are independent; the top only
// slices the packed buses and shares mode/clock-enable/reset.
// Reset asserts asynchronously; its release is expected synchronous to clk.
module dvi_tx_tmds_encoder
  import dvi_tx_pkg::*;
#(
  parameter int                     CHANNELS      = 3,
  parameter bit                     TERC4_EN      = 1'b1,
  parameter logic [CHANNELS*10-1:0] GUARD_PATTERN = {CHANNELS{GUARD_DEFAULT}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,
  input  logic [1:0]               in_mode,
  input  logic [CHANNELS*8-1:0]    in_d,
  input  logic [CHANNELS*2-1:0]    in_c,
  input  logic [CHANNELS*4-1:0]    in_terc4,
  output logic [CHANNELS*10-1:0]   out_d
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    dvi_tx_tmds_lane #(
      .TERC4_EN  (TERC4_EN),
      .GUARD_SYM (GUARD_PATTERN[10*g +: 10])
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .cke      (cke),
      .in_mode  (in_mode),
      .in_d     (in_d[8*g +: 8]),
      .in_c     (in_c[2*g +: 2]),
      .in_terc4 (in_terc4[4*g +: 4]),
      .out_d    (out_d[10*g +: 10])
    );
  end

endmodule
